// File: rtl/multiplier_accumulator_if.sv
// Slot-level bus between the multiplier pipeline and the per-thread accumulator:
// config writes and product in, registered running sum and flags out.
interface multiplier_accumulator_if #(
  parameter int WORD_WIDTH         = 36,
  parameter int GUARD_BITS         = 4,
  parameter int CONFIG_ADDR_WIDTH  = 10,
  parameter int THREAD_COUNT_WIDTH = 3
);
  logic [CONFIG_ADDR_WIDTH-1:0]  config_addr;
  logic [2:0]                    config_data;
  logic                          config_enable;
  logic [WORD_WIDTH-1:0]         R_low;
  logic [WORD_WIDTH-1:0]         R_high;
  logic                          R_valid;
  logic [WORD_WIDTH-1:0]         acc_low;
  logic [WORD_WIDTH-1:0]         acc_high;
  logic [GUARD_BITS-1:0]         acc_guard;
  logic                          acc_overflow;
  logic [THREAD_COUNT_WIDTH-1:0] thread;

  modport master (
    output config_addr, config_data, config_enable, R_low, R_high, R_valid,
    input  acc_low, acc_high, acc_guard, acc_overflow, thread
  );

  modport slave (
    input  config_addr, config_data, config_enable, R_low, R_high, R_valid,
    output acc_low, acc_high, acc_guard, acc_overflow, thread
  );
endinterface

// File: rtl/multiplier_accumulator.sv
// Round-robin per-thread accumulator: adds each slot's 2W-bit product into that
// thread's private AW-bit sum (signed/unsigned, wrap/saturate) with a sticky overflow.
module multiplier_accumulator #(
  parameter int WORD_WIDTH         = 36,
  parameter int GUARD_BITS         = 4,
  parameter int CONFIG_ADDR        = 0,
  parameter int CONFIG_ADDR_WIDTH  = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  multiplier_accumulator_if.slave   bus
);
  localparam int PW = 2 * WORD_WIDTH;
  localparam int AW = PW + GUARD_BITS;

  localparam logic [CONFIG_ADDR_WIDTH-1:0]  CTRL_ADDR  = CONFIG_ADDR_WIDTH'(CONFIG_ADDR);
  localparam logic [CONFIG_ADDR_WIDTH-1:0]  CLEAR_ADDR = CONFIG_ADDR_WIDTH'(CONFIG_ADDR + 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

  localparam logic [AW-1:0] ALL_ONES   = {AW{1'b1}};
  localparam logic [AW-1:0] SIGNED_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SIGNED_MIN = {1'b1, {(AW-1){1'b0}}};

  // Field order mirrors config_data: bit0 enable, bit1 signed, bit2 saturate.
  typedef struct packed {
    logic saturate;
    logic is_signed;
    logic enable;
  } ctrl_t;

  logic [THREAD_COUNT_WIDTH-1:0] thread_reg;
  logic [THREAD_COUNT_WIDTH-1:0] thread_next;
  logic [AW-1:0]                 acc_reg [THREAD_COUNT];
  logic                          ovf_reg [THREAD_COUNT];
  ctrl_t                         ctrl_reg [THREAD_COUNT];
  logic [AW-1:0]                 acc_out_reg;
  logic                          ovf_out_reg;

  ctrl_t         cur_ctrl;
  logic          ctrl_write;
  logic          clear_write;
  logic          accepted;
  logic [PW-1:0] product;
  logic [AW-1:0] ext_product;
  logic [AW-1:0] base;
  logic [AW:0]   sum_wide;
  logic          unsigned_ovf;
  logic          signed_ovf;
  logic          overflow;
  logic [AW-1:0] acc_next;
  logic          ovf_next;

  always_comb begin
    thread_next = (thread_reg == LAST_THREAD) ? '0 : thread_reg + 1'b1;
  end

  always_comb begin
    cur_ctrl     = ctrl_reg[thread_reg];
    ctrl_write   = bus.config_enable && (bus.config_addr == CTRL_ADDR);
    clear_write  = bus.config_enable && (bus.config_addr == CLEAR_ADDR);
    accepted     = bus.R_valid && cur_ctrl.enable;
    product      = {bus.R_high, bus.R_low};
    ext_product  = cur_ctrl.is_signed ? {{GUARD_BITS{product[PW-1]}}, product}
                                      : {{GUARD_BITS{1'b0}}, product};
    // A clear in the same slot makes the product land on a zero accumulator.
    base         = clear_write ? '0 : acc_reg[thread_reg];
    sum_wide     = {1'b0, base} + {1'b0, ext_product};
    unsigned_ovf = sum_wide[AW];
    signed_ovf   = (base[AW-1] == ext_product[AW-1]) && (sum_wide[AW-1] != base[AW-1]);
    overflow     = cur_ctrl.is_signed ? signed_ovf : unsigned_ovf;

    acc_next = base;
    ovf_next = clear_write ? 1'b0 : ovf_reg[thread_reg];
    if (accepted) begin
      ovf_next = ovf_next | overflow;
      if (overflow && cur_ctrl.saturate) begin
        if (cur_ctrl.is_signed) begin
          acc_next = base[AW-1] ? SIGNED_MIN : SIGNED_MAX;
        end else begin
          acc_next = ALL_ONES;
        end
      end else begin
        acc_next = sum_wide[AW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        acc_reg[i]  <= '0;
        ovf_reg[i]  <= 1'b0;
        ctrl_reg[i] <= '0;
      end
    end else begin
      acc_reg[thread_reg] <= acc_next;
      ovf_reg[thread_reg] <= ovf_next;
      if (ctrl_write) begin
        ctrl_reg[thread_reg] <= ctrl_t'(bus.config_data);
      end
    end
  end

  // thread_next never equals thread_reg, so the stored entry is already final
  // and no bypass of this slot's update is needed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thread_reg  <= '0;
      acc_out_reg <= '0;
      ovf_out_reg <= 1'b0;
    end else begin
      thread_reg  <= thread_next;
      acc_out_reg <= acc_reg[thread_next];
      ovf_out_reg <= ovf_reg[thread_next];
    end
  end

  assign bus.acc_low      = acc_out_reg[WORD_WIDTH-1:0];
  assign bus.acc_high     = acc_out_reg[PW-1:WORD_WIDTH];
  assign bus.acc_guard    = acc_out_reg[AW-1:PW];
  assign bus.acc_overflow = ovf_out_reg;
  assign bus.thread       = thread_reg;
endmodule

// File: doc/multiplier_accumulator.md
Name: multiplier_accumulator

Overview:
- Per-thread accumulate stage directly downstream of the multiplier pipeline.
- Consumes the 2W-bit product {R_high, R_low} each cycle for the thread whose slot it is, and adds it into that thread's private accumulator.
- Accumulation is configurable per thread: signed or unsigned, wrapping or saturating.
- Returns each thread's running sum, plus a sticky overflow flag, as read data on that thread's next slot.

Parameters:
- WORD_WIDTH, 36, width of R_low/R_high and of the acc_low/acc_high outputs.
- GUARD_BITS, 4, extra accumulator MSBs above the 2W product; accumulator width AW = 2*WORD_WIDTH + GUARD_BITS.
- CONFIG_ADDR, 0, base config address; CONFIG_ADDR is control, CONFIG_ADDR+1 is clear.
- CONFIG_ADDR_WIDTH, 10, width of config_addr.
- THREAD_COUNT, 8, number of round-robin threads (>=2).
- THREAD_COUNT_WIDTH, 3, clog2(THREAD_COUNT).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- config_addr  in  CONFIG_ADDR_WIDTH  config write address.
- config_data  in  3  bit0 accumulate_enable, bit1 signed, bit2 saturate (used only at CONFIG_ADDR).
- config_enable  in  1  config write strobe for current thread.
- R_low  in  WORD_WIDTH  product low word from multiplier pipeline.
- R_high  in  WORD_WIDTH  product high word.
- R_valid  in  1  product in this slot is to be accumulated.
- acc_low  out  WORD_WIDTH  accumulator bits [W-1:0] of current thread.
- acc_high  out  WORD_WIDTH  accumulator bits [2W-1:W].
- acc_guard  out  GUARD_BITS  accumulator bits [AW-1:2W].
- acc_overflow  out  1  sticky overflow/saturation flag of current thread.
- thread  out  THREAD_COUNT_WIDTH  index of thread owning this slot.

Behaviour:
- Thread counter:
  - Reset value 0.
  - Increments every cycle, wrapping THREAD_COUNT-1 -> 0.
  - All inputs in a cycle belong to `thread`.
- Per-thread state (THREAD_COUNT entries of each):
  - acc[AW], overflow, and ctrl{enable, signed, saturate}.
  - All reset to 0, so the default is disabled, unsigned, wrapping.
- Control write (config_enable=1, config_addr==CONFIG_ADDR):
  - Stores config_data[2:0] into ctrl[thread].
  - Takes effect from that thread's next slot; the current slot uses the old ctrl.
- Clear write (config_enable=1, config_addr==CONFIG_ADDR+1):
  - Forces acc[thread] and overflow[thread] to 0 in this slot's update.
  - If clear and an accepted product coincide, the result is acc = extended product, with overflow computed on 0 + product.
- Any other config_addr is ignored.
- Update rule, per slot of thread t:
  - The product is accepted iff R_valid && ctrl[t].enable.
  - Product extension: sign-extend bit 2W-1 to AW if signed, else zero-extend.
  - Sum = acc[t] (or 0 if clear) + extended product, computed at AW+1 bits.
  - Unsigned overflow: carry out of bit AW-1.
  - Signed overflow: both operands have the same sign and the sum's sign differs.
  - saturate=0: keep the wrapped AW-bit sum.
  - saturate=1, unsigned overflow: clamp to all ones.
  - saturate=1, signed overflow: clamp to 0 1...1 (positive) or 1 0...0 (negative), following the operand sign.
  - Any overflow sets overflow[t]; the flag is cleared only by a clear write or reset.
  - Product not accepted: acc[t] holds (clear still applies).
- Output timing:
  - Outputs are registered.
  - In the cycle where thread==t, outputs show acc[t]/overflow[t] as committed at the end of t's previous slot. Updates from the current slot appear THREAD_COUNT cycles later.
  - Reset value of all outputs is 0.
- Asynchronous reset mid-operation:
  - Immediately zeroes outputs, counter, all acc/overflow/ctrl.
  - The first slot after release is thread 0.
- Width rules:
  - No truncation of the 2W product.
  - Guard bits give at least 2^GUARD_BITS full-scale unsigned accumulations before wrap.

Test Plan:
(All with W=8, GUARD=4, AW=20, THREAD_COUNT=8.)
1. Reset: hold reset_n=0 mid-run, including a mid-accumulate -> all outputs 0, thread=0 on release, and a previously accumulated thread reads 0.
2. Unsigned accumulate: ctrl[3]=001, then R=0x0100 valid in three slots of thread 3 -> thread 3 reads 0x00100, 0x00200, then 0x00300 on successive slots. All other threads read 0. The slot of the ctrl write itself does not accumulate.
3. Signed wrap: ctrl[5]=011, product 0xFFFF valid twice -> acc 0xFFFFF, then 0xFFFFE, with overflow=0.
4. Saturation:
   - Unsigned: ctrl[2]=101, acc=0xFFFF0, product 0x0020 -> 0xFFFFF with overflow=1; a following 0x0000 product keeps overflow=1.
   - Signed: acc=0x7FFF0 plus product 0x0020 -> 0x7FFFF.
5. Simultaneous clear and product: acc[1]=0x00500 with overflow=1; clear write plus valid product 0x0007 -> next read 0x00007, overflow=0.
6. Isolation: control write and clear in thread 2's slot with R_valid=1 every cycle -> threads 0,1,3..7 accumulate unaffected, and R_valid=1 for disabled threads never changes their acc.
